// File: rtl/idp_sequencer.sv
// Instruction sequencer for a register-file/ALU datapath: accepts one instruction,
// drives it onto the datapath for rep+1 cycles, captures flags and pulses done.
module idp_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  input  logic [15:0] imm,
  input  logic [3:0]  rep,
  output logic        instr_ready,
  output logic [2:0]  dp_W_Adr,
  output logic [2:0]  dp_R_Adr,
  output logic [2:0]  dp_S_Adr,
  output logic [3:0]  dp_ALU_OP,
  output logic [15:0] dp_DS,
  output logic        dp_S_Sel,
  output logic        dp_W_En,
  input  logic        C_in,
  input  logic        N_in,
  input  logic        Z_in,
  output logic        C,
  output logic        N,
  output logic        Z,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [2:0]  w_q, w_d;
  logic [2:0]  r_q, r_d;
  logic [2:0]  s_q, s_d;
  logic        sel_q, sel_d;
  logic        nowb_q, nowb_d;
  logic [15:0] imm_q, imm_d;
  logic [2:0]  flags_q, flags_d;
  logic        exec;

  // Reserved instruction bit carries no meaning.
  logic unused_instr_bit;
  assign unused_instr_bit = instr[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      w_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      sel_q   <= 1'b0;
      nowb_q  <= 1'b0;
      imm_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      w_q     <= w_d;
      r_q     <= r_d;
      s_q     <= s_d;
      sel_q   <= sel_d;
      nowb_q  <= nowb_d;
      imm_q   <= imm_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    w_d     = w_q;
    r_d     = r_q;
    s_d     = s_q;
    sel_d   = sel_q;
    nowb_d  = nowb_q;
    imm_d   = imm_q;
    flags_d = flags_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d    = instr[15:12];
          w_d     = instr[11:9];
          r_d     = instr[8:6];
          s_d     = instr[5:3];
          sel_d   = instr[2];
          nowb_d  = instr[1];
          imm_d   = imm;
          cnt_d   = rep;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Flags are captured every EXEC cycle, even for no-writeback compares.
        flags_d = {C_in, N_in, Z_in};
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath controls decode from registered state only; zero outside EXEC.
  assign exec        = (state_q == EXEC);
  assign dp_ALU_OP   = exec ? op_q : '0;
  assign dp_W_Adr    = exec ? w_q  : '0;
  assign dp_R_Adr    = exec ? r_q  : '0;
  assign dp_S_Adr    = exec ? s_q  : '0;
  assign dp_S_Sel    = exec & sel_q;
  assign dp_DS       = (exec & sel_q) ? imm_q : '0;
  assign dp_W_En     = exec & ~nowb_q;
  assign {C, N, Z}   = flags_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign instr_ready = (state_q == IDLE) & reset;

endmodule

// File: tb/tb_idp_sequencer.sv
// Directed bench for idp_sequencer: vector table of single instructions plus
// hand-written handshake and mid-operation reset sequences.
module tb_idp_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] imm;
  logic [3:0]  rep;
  logic        instr_ready;
  logic [2:0]  dp_W_Adr, dp_R_Adr, dp_S_Adr;
  logic [3:0]  dp_ALU_OP;
  logic [15:0] dp_DS;
  logic        dp_S_Sel, dp_W_En;
  logic        C_in, N_in, Z_in;
  logic        C, N, Z;
  logic        busy, done;

  int unsigned checks = 0;
  int unsigned failures = 0;

  idp_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .imm         (imm),
    .rep         (rep),
    .instr_ready (instr_ready),
    .dp_W_Adr    (dp_W_Adr),
    .dp_R_Adr    (dp_R_Adr),
    .dp_S_Adr    (dp_S_Adr),
    .dp_ALU_OP   (dp_ALU_OP),
    .dp_DS       (dp_DS),
    .dp_S_Sel    (dp_S_Sel),
    .dp_W_En     (dp_W_En),
    .C_in        (C_in),
    .N_in        (N_in),
    .Z_in        (Z_in),
    .C           (C),
    .N           (N),
    .Z           (Z),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [3:0]  rep;
    logic [3:0]  e_op;
    logic [2:0]  e_w;
    logic [2:0]  e_r;
    logic [2:0]  e_s;
    logic        e_sel;
    logic [15:0] e_ds;
    logic        e_wen;
    int          e_cycles;
    logic [2:0]  fin;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dp_zero(input string tag);
    check({tag, "_alu"}, {28'd0, dp_ALU_OP}, 32'd0);
    check({tag, "_adr"}, {23'd0, dp_W_Adr, dp_R_Adr, dp_S_Adr}, 32'd0);
    check({tag, "_ds"},  {16'd0, dp_DS}, 32'd0);
    check({tag, "_sel_wen"}, {30'd0, dp_S_Sel, dp_W_En}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h2A50, 16'hBEEF, 4'd0,  4'h2, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b1, 1,  3'b101};
    vecs[1] = '{16'h7E3C, 16'h1234, 4'd1,  4'h7, 3'd7, 3'd0, 3'd7, 1'b1, 16'h1234, 1'b1, 2,  3'b010};
    vecs[2] = '{16'h14E1, 16'hFFFF, 4'd3,  4'h1, 3'd2, 3'd3, 3'd4, 1'b0, 16'h0000, 1'b1, 4,  3'b111};
    vecs[3] = '{16'hC3AE, 16'h00A5, 4'd2,  4'hC, 3'd1, 3'd6, 3'd5, 1'b1, 16'h00A5, 1'b0, 3,  3'b001};
    vecs[4] = '{16'hF000, 16'h5555, 4'd15, 4'hF, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 16, 3'b100};
    vecs[5] = '{16'h0002, 16'h0000, 4'd0,  4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 1,  3'b000};

    reset = 1'b0; instr_valid = 1'b0; instr = '0; imm = '0; rep = '0;
    {C_in, N_in, Z_in} = 3'b111;
    #3;
    check("rst_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_flags", {29'd0, C, N, Z}, 32'd0);
    check_dp_zero("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, instr_ready}, 32'd1);
      check("idle_busy_done", {30'd0, busy, done}, 32'd0);
      check_dp_zero("idle");
      instr_valid = 1'b1; instr = vecs[i].instr; imm = vecs[i].imm; rep = vecs[i].rep;
      @(posedge clk); #1;
      instr_valid = 1'b0; instr = ~vecs[i].instr; imm = ~vecs[i].imm; rep = ~vecs[i].rep;
      for (int c = 0; c < vecs[i].e_cycles; c++) begin
        @(negedge clk);
        check("exec_state", {29'd0, busy, done, instr_ready}, 32'b100);
        check("exec_alu", {28'd0, dp_ALU_OP}, {28'd0, vecs[i].e_op});
        check("exec_adr", {23'd0, dp_W_Adr, dp_R_Adr, dp_S_Adr},
              {23'd0, vecs[i].e_w, vecs[i].e_r, vecs[i].e_s});
        check("exec_sel", {31'd0, dp_S_Sel}, {31'd0, vecs[i].e_sel});
        check("exec_ds", {16'd0, dp_DS}, {16'd0, vecs[i].e_ds});
        check("exec_wen", {31'd0, dp_W_En}, {31'd0, vecs[i].e_wen});
        {C_in, N_in, Z_in} = (c == vecs[i].e_cycles - 1) ? vecs[i].fin : ~vecs[i].fin;
      end
      @(negedge clk);
      check("done_state", {29'd0, busy, done, instr_ready}, 32'b110);
      check("done_flags", {29'd0, C, N, Z}, {29'd0, vecs[i].fin});
      check_dp_zero("done");
      {C_in, N_in, Z_in} = ~vecs[i].fin;
      @(negedge clk);
      check("post_state", {29'd0, busy, done, instr_ready}, 32'b001);
      check("post_flags_hold", {29'd0, C, N, Z}, {29'd0, vecs[i].fin});
    end

    // Handshake: valid held high, second instruction presented while busy.
    @(negedge clk);
    instr_valid = 1'b1; instr = 16'h2A50; imm = 16'h0; rep = 4'd1;
    @(posedge clk); #1;
    instr = 16'h14E1; rep = 4'd0;
    @(negedge clk);
    check("hs_exec1_op", {28'd0, dp_ALU_OP}, 32'h2);
    check("hs_exec1_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    check("hs_exec2_op_w", {25'd0, dp_ALU_OP, dp_W_Adr}, {25'd0, 4'h2, 3'd5});
    @(negedge clk);
    check("hs_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("hs_idle_ready", {30'd0, instr_ready, busy}, 32'b10);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("hs_b_op_w", {25'd0, dp_ALU_OP, dp_W_Adr}, {25'd0, 4'h1, 3'd2});
    check("hs_b_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("hs_b_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("hs_b_idle", {31'd0, instr_ready}, 32'd1);

    // Reset asserted in the third EXEC cycle of a rep=7 instruction.
    instr_valid = 1'b1; instr = 16'h14E1; imm = 16'h0; rep = 4'd7;
    {C_in, N_in, Z_in} = 3'b111;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rm_exec3_wen", {31'd0, dp_W_En}, 32'd1);
    check("rm_flags_before", {29'd0, C, N, Z}, 32'b111);
    #2 reset = 1'b0;
    #1;
    check("rm_wen", {31'd0, dp_W_En}, 32'd0);
    check("rm_flags", {29'd0, C, N, Z}, 32'd0);
    check("rm_state", {29'd0, busy, done, instr_ready}, 32'd0);
    check_dp_zero("rm");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rm_hold", {29'd0, done, dp_W_En, instr_ready}, 32'd0);
    end
    reset = 1'b1; instr_valid = 1'b1; instr = 16'h2A50; rep = 4'd0;
    {C_in, N_in, Z_in} = 3'b010;
    #1;
    check("rel_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("rel_exec", {24'd0, dp_W_En, dp_ALU_OP, dp_W_Adr}, {24'd0, 1'b1, 4'h2, 3'd5});
    @(negedge clk);
    check("rel_done", {31'd0, done}, 32'd1);
    check("rel_flags", {29'd0, C, N, Z}, 32'b010);
    @(negedge clk);
    check("rel_idle", {30'd0, instr_ready, busy}, 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idp_sequencer.md
IDP_SEQUENCER -- requirements
Module: idp_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the clock and reset is active-low asynchronous.
REQ-002 The ports SHALL be, per line: name  direction  width  meaning.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  16  [15:12] ALU op, [11:9] write addr, [8:6] R addr, [5:3] S addr, [2] imm select, [1] no-writeback, [0] reserved (ignored).
- imm  in  16  immediate, sampled with instr.
- rep  in  4  extra repetitions; execute count = rep+1.
- instr_ready  out  1  block can accept an instruction.
- dp_W_Adr, dp_R_Adr, dp_S_Adr  out  3 each  datapath register addresses.
- dp_ALU_OP  out  4  datapath ALU opcode.
- dp_DS  out  16  datapath external operand.
- dp_S_Sel  out  1  1 = DS operand, 0 = register S.
- dp_W_En  out  1  datapath register-file write enable.
- C_in, N_in, Z_in  in  1 each  live datapath flags.
- C, N, Z  out  1 each  captured flags.
- busy  out  1  instruction in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-004 IDLE behaviour:
- instr_ready SHALL be 1.
- On a rising clk with instr_valid=1, the block SHALL latch instr, imm and rep, load cnt=rep, and go to EXEC.
REQ-005 In IDLE with instr_valid=0 the FSM SHALL stay in IDLE and all dp_* outputs SHALL be 0.
REQ-006 instr_ready SHALL be 0 in EXEC and DONE, and instr_valid SHALL be ignored in those states.
REQ-007 EXEC outputs:
- dp_ALU_OP, dp_W_Adr, dp_R_Adr and dp_S_Adr SHALL come from the latched instruction fields.
- dp_S_Sel SHALL equal latched bit[2].
- dp_DS SHALL equal the latched imm when bit[2]=1, otherwise 0.
- dp_W_En SHALL equal NOT latched bit[1].
REQ-008 EXEC sequencing:
- Each EXEC cycle is one ALU operation.
- At the end of each EXEC cycle the block SHALL register C_in, N_in and Z_in into C, N and Z.
- If cnt=0 it SHALL go to DONE; otherwise it SHALL decrement cnt and stay in EXEC.
REQ-009 The block SHALL spend exactly rep+1 consecutive EXEC cycles per instruction, with dp_W_En high in every one of them unless no-writeback is set.
REQ-010 In DONE, done SHALL be 1 for exactly one cycle, all dp_* outputs SHALL be 0, and the next state SHALL be IDLE unconditionally.
REQ-011 Latency: with acceptance at edge k, the EXEC cycles SHALL be the cycles after edges k..k+rep; done SHALL be high after edge k+rep+1; instr_ready SHALL be high again after edge k+rep+2.
REQ-012 busy SHALL be 1 in EXEC and DONE and 0 in IDLE.
REQ-013 C, N and Z SHALL hold their last captured values outside EXEC, including while no-writeback instructions run; the flags SHALL still update in no-writeback mode (compare use).
REQ-014 rep=15 SHALL produce 16 EXEC cycles, and the 4-bit cnt SHALL NOT wrap below 0.
REQ-015 dp_* outputs SHALL be registered or decoded from registered state only, with no combinational path from instr_valid, instr, imm or rep.

Reset
REQ-016 Asserting reset=0 SHALL immediately force:
- state to IDLE and cnt to 0;
- all latched fields to 0;
- dp_W_En, and every other dp_* output, to 0;
- C=N=Z=0;
- busy=0 and done=0;
- instr_ready=0 while reset is low.
REQ-017 A reset asserted during EXEC SHALL abort the instruction, and no further dp_W_En pulse SHALL occur.
REQ-018 After reset deasserts, instr_ready SHALL be 1 from the first clk edge and an instruction SHALL be accepted on that edge if valid.

Verification
REQ-019 Single op: instr=0x2A50 (op 2, W=5, R=1, S=2, reg operand), rep=0 ->
- exactly one EXEC cycle with dp_W_En=1, dp_W_Adr=5, dp_R_Adr=1, dp_S_Adr=2, dp_S_Sel=0, dp_DS=0;
- done on the following cycle.
REQ-020 Immediate: instr bit[2]=1, imm=0x1234 -> dp_S_Sel=1 and dp_DS=0x1234 during EXEC only; dp_DS=0 in IDLE and DONE.
REQ-021 Repeat: rep=3 -> 4 consecutive dp_W_En pulses, done 1 cycle after the 4th, C/N/Z equal to the C_in/N_in/Z_in values sampled in the 4th EXEC cycle.
REQ-022 Compare: bit[1]=1, Z_in=1 during EXEC -> dp_W_En=0 throughout and Z=1 after EXEC.
REQ-023 Handshake: instr_valid held high across two instructions -> the second is accepted only when instr_ready=1, and instr changes while busy have no effect.
REQ-024 Reset mid-op: rep=7, reset=0 at the 3rd EXEC cycle -> dp_W_En=0 immediately, C=N=Z=0, and no done pulse; after release a new instruction executes normally.
